// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with load, enable, wrap/saturate
// limit handling, terminal count and sticky overflow.
module updown_counter_n #(
    parameter int              W   = 4,
    parameter longint unsigned MAX = (64'd1 << W) - 64'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         m,
    input  logic         sat,
    input  logic         ld,
    input  logic [W-1:0] din,
    output logic [W-1:0] out,
    output logic         tc,
    output logic         ovf
);

    localparam logic [W-1:0] TOP  = MAX[W-1:0];
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = W'(1);

    logic         at_top;
    logic         at_bot;
    logic         at_lim;
    logic [W-1:0] ld_val;
    logic [W-1:0] wrap_val;
    logic [W-1:0] step_val;

    assign at_top = (out == TOP);
    assign at_bot = (out == ZERO);
    assign at_lim = m ? at_bot : at_top;
    assign tc     = at_lim;

    // Out-of-range load values clamp to the top count.
    assign ld_val   = (din > TOP) ? TOP : din;
    assign wrap_val = m ? TOP : ZERO;
    assign step_val = m ? (out - ONE) : (out + ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= ZERO;
            ovf <= 1'b0;
        end else if (ld) begin
            out <= ld_val;
            ovf <= 1'b0;
        end else if (en) begin
            if (at_lim) begin
                ovf <= 1'b1;
                if (!sat) begin
                    out <= wrap_val;
                end
            end else begin
                out <= step_val;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Vector-table bench for updown_counter_n with W=4, MAX=9.
module tb_updown_counter_n;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         m   = 1'b0;
    logic         sat = 1'b0;
    logic         ld  = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] out;
    logic         tc;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    typedef struct {
        logic         rst;
        logic         ld;
        logic         en;
        logic         m;
        logic         sat;
        logic [W-1:0] din;
        logic [W-1:0] out;
        logic         ovf;
        logic         tc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    updown_counter_n #(.W(W), .MAX(9)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .m(m),
        .sat(sat),
        .ld(ld),
        .din(din),
        .out(out),
        .tc(tc),
        .ovf(ovf)
    );

    // The count must never leave 0..9 once reset has been applied.
    always @(negedge clk) begin
        if (armed) begin
            assert (out <= 4'd9)
            else begin
                errors++;
                $error("FAIL range out=%0d limit=9", out);
            end
        end
    end

    function automatic void add(input logic r, input logic l, input logic e,
                                input logic mm, input logic s, input int d,
                                input int o, input logic ov, input logic t);
        vec_t v;
        v = '{r, l, e, mm, s, 4'(d), 4'(o), ov, t};
        tbl.push_back(v);
    endfunction

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst;
        ld  = v.ld;
        en  = v.en;
        m   = v.m;
        sat = v.sat;
        din = v.din;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out !== e.out) begin
            errors++;
            $display("FAIL out vec %0d got %0d exp %0d", idx, out, e.out);
        end
        checks++;
        if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf vec %0d got %0b exp %0b", idx, ovf, e.ovf);
        end
        checks++;
        if (tc !== e.tc) begin
            errors++;
            $display("FAIL tc vec %0d got %0b exp %0b", idx, tc, e.tc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout bench did not finish");
        $fatal(1);
    end

    initial begin
        // rst ld en m sat din | out ovf tc
        add(1, 0, 0, 0, 0, 0,  0, 0, 0);
        for (int i = 1; i <= 12; i++)
            add(0, 0, 1, 0, 0, 0, i % 10, (i >= 10), ((i % 10) == 9));
        // down wrap from 2
        add(0, 1, 0, 1, 0, 2,  2, 0, 0);
        add(0, 0, 1, 1, 0, 0,  1, 0, 0);
        add(0, 0, 1, 1, 0, 0,  0, 0, 1);
        add(0, 0, 1, 1, 0, 0,  9, 1, 0);
        add(0, 0, 1, 1, 0, 0,  8, 1, 0);
        // saturate at top, then reverse
        add(0, 1, 0, 0, 1, 8,  8, 0, 0);
        add(0, 0, 1, 0, 1, 0,  9, 0, 1);
        add(0, 0, 1, 0, 1, 0,  9, 1, 1);
        add(0, 0, 1, 0, 1, 0,  9, 1, 1);
        add(0, 0, 1, 1, 1, 0,  8, 1, 0);
        add(0, 0, 1, 1, 1, 0,  7, 1, 0);
        add(0, 0, 0, 1, 0, 0,  7, 1, 0);
        add(0, 0, 0, 0, 1, 0,  7, 1, 0);
        // load priority, clamp and exact-top load
        add(0, 1, 1, 0, 0, 13, 9, 0, 1);
        add(1, 1, 1, 0, 0, 5,  0, 0, 0);
        add(0, 1, 1, 1, 1, 15, 9, 0, 0);
        add(0, 1, 0, 0, 0, 10, 9, 0, 1);
        add(0, 1, 1, 1, 0, 9,  9, 0, 0);
        add(0, 1, 1, 0, 0, 0,  0, 0, 0);
        // saturate at bottom
        add(0, 0, 1, 1, 1, 0,  0, 1, 1);
        add(0, 0, 1, 1, 1, 0,  0, 1, 1);

        foreach (tbl[i]) begin
            apply(i, tbl[i]);
            armed = 1'b1;
        end

        // Enable low for five cycles at 5 while other controls wiggle.
        apply(100, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++)
            apply(101 + i, '{1'b0, 1'b0, 1'b0, 1'(i), 1'(i >> 1),
                             4'(i), 4'd5, 1'b0, 1'b0});

        // Direction flip every enabled edge.
        for (int i = 0; i < 4; i++)
            apply(110 + i, '{1'b0, 1'b0, 1'b1, 1'(i), 1'b0,
                             4'd0, ((i % 2) == 0) ? 4'd6 : 4'd5, 1'b0, 1'b0});

        // Build ovf=1 at out=7, then reset mid-count with m=1.
        apply(120, '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1});
        apply(121, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0});
        apply(122, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0});
        apply(123, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd7, 1'b1, 1'b0});
        apply(124, '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 1'b1});
        apply(125, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0});

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue left %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised synchronous up/down counter, the next generation of the team's fixed 3-bit T-flip-flop up/down counter. It adds:
- configurable width and modulus,
- count enable and synchronous parallel load,
- selectable wrap or saturate behaviour at the count limits,
- terminal-count and sticky overflow flags.

It serves as the general-purpose counter primitive for dividers, sequencers and event counting in the design.

## Interface
- W, 4, counter width in bits; legal range 2..32.
- MAX, 2**W-1, top count value; count range is 0..MAX; legal range 1..2**W-1.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; when 0, the count holds.
- m  input  1  direction: 0 = up, 1 = down (same polarity as the existing counter).
- sat  input  1  limit mode: 0 = wrap, 1 = saturate.
- ld  input  1  synchronous parallel load strobe.
- din  input  W  load value.
- out  output  W  registered count.
- tc  output  1  terminal count for the current direction (combinational from out and m).
- ovf  output  1  sticky limit-crossing flag (registered).

## Operation
- Per-edge priority: rst > ld > en > hold.
- rst=1: out <= 0, ovf <= 0. All other inputs are ignored that edge.
- ld=1: the load ignores en, m and sat, and it clears ovf.
  - out <= din if din <= MAX.
  - Otherwise out <= MAX (clamp).
- en=1, m=0 (up):
  - out < MAX: out <= out+1.
  - out == MAX, sat=0: out <= 0 and ovf <= 1.
  - out == MAX, sat=1: out holds at MAX and ovf <= 1.
- en=1, m=1 (down):
  - out > 0: out <= out-1.
  - out == 0, sat=0: out <= MAX and ovf <= 1.
  - out == 0, sat=1: out holds at 0 and ovf <= 1.
- en=0, ld=0: out and ovf hold.
- tc = (m==0 && out==MAX) || (m==1 && out==0). tc is independent of en.
- Arithmetic is W bits, unsigned. The MAX compare uses the W-bit constant. No intermediate value exceeds W bits, because the limit compare happens before any increment or decrement.
- ovf stays set until rst or ld, even while counting continues.
- Changing m mid-count takes effect on the next enabled edge; there is no turnaround cycle.
- out stays within 0..MAX at all times after reset. Any out > MAX is a design error, and the bench asserts on it.

## Timing
- Latency: one clock from an input at an edge to out/ovf valid after that edge.
- tc follows out and m combinationally within the same cycle.
- Reset values, in the cycle after rst: out=0, ovf=0, tc = m.
- Simultaneous rst and ld: reset wins, out=0.
- Simultaneous ld and en: the load wins; no count is applied to the loaded value that edge.
- Reset mid-count: out returns to 0 on that edge regardless of direction or sat.
- Before the first reset, outputs are X. The bench applies rst for at least 1 cycle at start.
- No handshake; every edge with en=1 is one count step.

## Test plan
All scenarios use W=4, MAX=9.
- Reset then up count: rst 1 cycle, then en=1, m=0, sat=0 for 12 cycles.
  - out follows 0,1,…,9,0,1,2.
  - tc=1 only while out=9.
  - ovf rises on the edge 9->0 and stays 1.
- Down wrap: ld din=2, then en=1, m=1, sat=0.
  - out follows 2,1,0,9,8.
  - tc=1 at out=0.
  - ovf=1 from the 0->9 edge.
- Saturate: ld din=8, then en=1, m=0, sat=1 for 4 cycles.
  - out follows 8,9,9,9.
  - ovf=1 after the first held edge.
  - Then switch m=1: out goes 8,7.
- Load priority and clamp:
  - ld=1, din=13 with en=1: out=9, ovf cleared.
  - Same edge as rst=1: out=0.
- Enable hold and direction flip:
  - en=0 for 5 cycles at out=5: out stays 5.
  - Toggle m every cycle with en=1: out alternates 6,5,6,5.
- Reset mid-operation: rst asserted at out=7 with ovf=1 -> next cycle out=0, ovf=0, tc=m.
